// File: rtl/bram_burst_reader_if.sv
// Valid/ready word stream with an end-of-burst marker, as emitted by bram_burst_reader.
interface bram_burst_reader_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/bram_burst_reader.sv
// Streams len consecutive BRAM words from base_addr as a valid/ready burst.
// The BRAM output register is the only pipeline stage; out_ready freezes it under backpressure.
//
// state | meaning
// IDLE  | waiting for start; bram_out_ready held low
// RUN   | fetching and streaming words until the last beat is accepted
module bram_burst_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bram_raddr,
    output logic                  bram_out_ready,
    input  logic [DATA_WIDTH-1:0] bram_out,
    bram_burst_reader_if.master   m
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   rem;
    logic                  vld;
    logic                  lst;
    logic                  adv;

    // The BRAM output register only advances when the current word is free to be replaced.
    assign adv            = ~vld | m.ready;
    assign bram_out_ready = (state == RUN) & adv;
    assign bram_raddr     = addr;
    assign busy           = (state == RUN);
    assign m.data         = bram_out;
    assign m.valid        = vld;
    assign m.last         = lst;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= '0;
            rem   <= '0;
            vld   <= 1'b0;
            lst   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    vld <= 1'b0;
                    lst <= 1'b0;
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= RUN;
                            addr  <= base_addr;
                            rem   <= len;
                        end
                    end
                end
                RUN: begin
                    if (adv) begin
                        if (rem != '0) begin
                            vld  <= 1'b1;
                            lst  <= (rem == REM_ONE);
                            addr <= addr + ADDR_ONE;
                            rem  <= rem - REM_ONE;
                        end else begin
                            vld <= 1'b0;
                            lst <= 1'b0;
                        end
                    end
                    if (vld && m.ready && lst) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
